// File: rtl/halving_sequencer.sv
// Control stage for the divide-by-two datapath: accepts A and N, steps q once per halving,
// and returns A / 2^N. Define HALVING_ROUND_EN to round half up on the last shifted-out bit.
module halving_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [CNT_W-1:0] shamt,
  output logic [CNT_W-1:0] q,
  output logic [CNT_W-1:0] qbar,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [CNT_W-1:0] n_r;
  logic [CNT_W-1:0] n_nxt_s;
  logic [CNT_W-1:0] q_r;
  logic [CNT_W-1:0] q_nxt_s;
  logic [CNT_W-1:0] qbar_r;
  logic [CNT_W:0]   step_s;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] final_s;
  logic             in_ready_r;
  logic             busy_r;
  logic             out_valid_r;

`ifdef HALVING_ROUND_EN
  logic rbit_r;
  logic rbit_nxt_s;

  // Adds back the last bit shifted out; cannot overflow because acc <= 2^(WIDTH-1)-1 after a shift.
  function automatic logic [WIDTH-1:0] round_up(input logic [WIDTH-1:0] acc, input logic rbit);
    round_up = acc + {{(WIDTH-1){1'b0}}, rbit};
  endfunction
`endif

  // One extra bit so the step count compares cleanly against n even at the top of the range.
  assign step_s = {1'b0, q_r} + {{CNT_W{1'b0}}, 1'b1};

  // Next-state and datapath update for the IDLE/LOAD/SHIFT/DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    n_nxt_s     = n_r;
    q_nxt_s     = q_r;
`ifdef HALVING_ROUND_EN
    rbit_nxt_s  = rbit_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = ST_LOAD;
          acc_nxt_s   = a;
          n_nxt_s     = shamt;
          q_nxt_s     = {CNT_W{1'b0}};
`ifdef HALVING_ROUND_EN
          rbit_nxt_s  = 1'b0;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (n_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_nxt_s = acc_r >> 1;
        q_nxt_s   = step_s[CNT_W-1:0];
`ifdef HALVING_ROUND_EN
        rbit_nxt_s = acc_r[0];
`endif
        if (step_s == {1'b0, n_r}) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
          q_nxt_s     = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        q_nxt_s     = {CNT_W{1'b0}};
      end
    endcase
  end

  // Value captured into result on entry to DONE, computed from the post-step accumulator.
  always_comb begin
`ifdef HALVING_ROUND_EN
    final_s = round_up(acc_nxt_s, rbit_nxt_s);
`else
    final_s = acc_nxt_s;
`endif
  end

  // State, datapath and registered status outputs; reset discards any work in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      acc_r       <= {WIDTH{1'b0}};
      n_r         <= {CNT_W{1'b0}};
      q_r         <= {CNT_W{1'b0}};
      qbar_r      <= {CNT_W{1'b1}};
      result_r    <= {WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      n_r         <= n_nxt_s;
      q_r         <= q_nxt_s;
      qbar_r      <= ~q_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      busy_r      <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_SHIFT);
      out_valid_r <= (state_nxt_s == ST_DONE);
      if ((state_nxt_s == ST_DONE) && (state_r != ST_DONE)) begin
        result_r <= final_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

`ifdef HALVING_ROUND_EN
  // Last bit shifted out of the accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      rbit_r <= 1'b0;
    end else begin
      rbit_r <= rbit_nxt_s;
    end
  end
`endif

  assign in_ready  = in_ready_r;
  assign q         = q_r;
  assign qbar      = qbar_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;

endmodule

// File: tb/tb_halving_sequencer.sv
// Randomized self-checking bench for halving_sequencer against an arithmetic reference model.
module tb_halving_sequencer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [3:0] shamt;
  logic [3:0] q;
  logic [3:0] qbar;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;

  int n_checks;
  int n_pass;

  halving_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .shamt(shamt), .q(q), .qbar(qbar), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: floor(A / 2^N), optionally rounded half up on the last discarded bit.
  function automatic int model_result(input int av, input int nv);
    int r;
    r = av / (1 << nv);
`ifdef HALVING_ROUND_EN
    if (nv >= 1) r = r + ((av / (1 << (nv - 1))) % 2);
`endif
    return r;
  endfunction

  task automatic do_op(input int av, input int nv, input int hold);
    int lat;
    int exp_r;
    exp_r = model_result(av, nv);
    @(negedge clk);
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    a = av[7:0];
    shamt = nv[3:0];
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom);
    shamt = 4'($urandom);
    @(negedge clk);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("not_ready_busy", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, nv + 1);
    check("result", {24'd0, result}, exp_r);
    check("q_done", {28'd0, q}, nv);
    check("qbar_done", {28'd0, qbar}, (~nv) & 15);
    check("busy_done", {31'd0, busy}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a = 8'($urandom);
      shamt = 4'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_result", {24'd0, result}, exp_r);
      check("hold_q", {28'd0, q}, nv);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("handoff_valid", {31'd0, out_valid}, 32'd0);
    check("handoff_ready", {31'd0, in_ready}, 32'd1);
    check("handoff_q", {28'd0, q}, 32'd0);
    check("handoff_qbar", {28'd0, qbar}, 32'd15);
    check("handoff_result", {24'd0, result}, exp_r);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 8'd0;
    shamt = 4'd0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_q", {28'd0, q}, 32'd0);
    check("rst_qbar", {28'd0, qbar}, 32'd15);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    do_op(55, 1, 0);
    do_op(200, 3, 1);
    do_op(55, 0, 0);
    do_op(255, 8, 0);
    do_op(255, 15, 0);
    do_op(171, 5, 5);

    // Reset during SHIFT after two steps.
    @(negedge clk);
    a = 8'd240;
    shamt = 4'd6;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_q", {28'd0, q}, 32'd2);
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_q", {28'd0, q}, 32'd0);
    check("mid_rst_qbar", {28'd0, qbar}, 32'd15);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_result", {24'd0, result}, 32'd0);
    do_op(240, 6, 0);

    for (int k = 0; k < 25; k++) begin
      do_op(int'($urandom_range(255, 0)), int'($urandom_range(15, 0)), int'($urandom_range(3, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
